// File: rtl/axis_alu_rr_arbiter.sv
// axis_alu_rr_arbiter
// NUM_CH operand streams feed one ALU through a round-robin arbiter. One beat
// is accepted per cycle. Results go into an output FIFO tagged {err, channel},
// and the FIFO head drives the AXI-Stream master.
module axis_alu_rr_arbiter #(
    parameter int  DATA_WIDTH = 16,
    parameter int  OPND_WIDTH = 6,
    parameter int  NUM_CH     = 4,
    parameter int  FIFO_DEPTH = 4,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_CH-1:0]                  axis_tvalid,
    output logic [NUM_CH-1:0]                  axis_tready,
    input  logic [NUM_CH*DATA_WIDTH-1:0]       axis_tdata,
    input  logic [NUM_CH*4-1:0]                opCode,
    output logic                               axim_tvalid,
    input  logic                               axim_tready,
    output logic [DATA_WIDTH-1:0]              axim_tdata,
    output logic [CH_W:0]                      axim_tuser,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + CH_W + DATA_WIDTH;
    localparam int LO_W  = DATA_WIDTH - 2*OPND_WIDTH;

    logic [CH_W-1:0]       r_last_grant;
    logic                  r_active;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];

    logic [OPND_WIDTH-1:0] w_ch_a  [NUM_CH];
    logic [OPND_WIDTH-1:0] w_ch_b  [NUM_CH];
    logic [3:0]            w_ch_op [NUM_CH];
    logic [NUM_CH-1:0]     w_unused_lo;

    logic                  w_any;
    logic [CH_W-1:0]       w_grant;
    logic [CH_W-1:0]       w_idx;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [OPND_WIDTH-1:0] w_a;
    logic [OPND_WIDTH-1:0] w_b;
    logic [OPND_WIDTH-1:0] w_diff;
    logic [3:0]            w_op;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_err;
    logic [ENT_W-1:0]      w_head;

    // Unpack each channel: A in the top bits, B directly below; the rest is ignored.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign w_ch_a[i]      = axis_tdata[i*DATA_WIDTH + DATA_WIDTH - 1 -: OPND_WIDTH];
        assign w_ch_b[i]      = axis_tdata[i*DATA_WIDTH + DATA_WIDTH - OPND_WIDTH - 1 -: OPND_WIDTH];
        assign w_ch_op[i]     = opCode[i*4 +: 4];
        assign w_unused_lo[i] = ^axis_tdata[i*DATA_WIDTH +: LO_W];
    end

    // Round-robin search: first valid channel after the last granted one.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = CH_W'((int'(r_last_grant) + k) % NUM_CH);
            if (!w_any && axis_tvalid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // No pass-through when full: a same-cycle pop does not free a slot for this beat.
    assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push = r_active && w_any && !w_full;
    assign w_pop  = axim_tvalid && axim_tready;

    // One-hot ready toward the granted channel only.
    always_comb begin
        axis_tready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            axis_tready[i] = w_push && (w_grant == CH_W'(i));
        end
    end

    assign w_a    = w_ch_a[w_grant];
    assign w_b    = w_ch_b[w_grant];
    assign w_op   = w_ch_op[w_grant];
    assign w_diff = w_a - w_b;

    // ALU on the granted beat; illegal opcodes yield zero with err set.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (w_op)
            4'd0:    w_res = DATA_WIDTH'(w_a) + DATA_WIDTH'(w_b);
            4'd1:    w_res = DATA_WIDTH'(w_a & w_b);
            4'd2:    w_res = DATA_WIDTH'(w_a | w_b);
            4'd3:    w_res = DATA_WIDTH'(w_a ^ w_b);
            4'd4:    w_res = DATA_WIDTH'(w_diff);
            4'd5:    w_res = DATA_WIDTH'(w_a) * DATA_WIDTH'(w_b);
            default: w_err = 1'b1;
        endcase
    end

    // Ready is held low until the first clock after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_active <= 1'b0;
        else       r_active <= 1'b1;
    end

    // Priority pointer moves only on a completed handshake; reset favours channel 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       r_last_grant <= CH_W'(NUM_CH - 1);
        else if (w_push) r_last_grant <= w_grant;
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents need no reset because valid is derived from the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_err, w_grant, w_res};
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign axim_tvalid = (r_count != '0);
    assign axim_tdata  = axim_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
    assign axim_tuser  = axim_tvalid ? w_head[ENT_W-1:DATA_WIDTH] : '0;
    assign fifo_count  = r_count;

endmodule
